// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - shared types and Gray helpers for the quadrature input filter
package quad_enc_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Forward sequence is 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray_next(input logic [1:0] code);
    logic [1:0] nxt;
    case (code)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - plain multi-flop synchroniser, falling-edge clocked
module sync_chain #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             Clkb,
  input  logic             RSTb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(negedge Clkb or negedge RSTb) begin
    if (!RSTb) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], d};
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/quad_enc_filter.sv
// rtl/quad_enc_filter.sv - synchronise, debounce and classify quadrature A/B pins
module quad_enc_filter
  import quad_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = $clog2(DEB_CYCLES + 1)
) (
  input  logic       Clkb,
  input  logic       RSTb,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       err_clr,
  output logic [1:0] enc_inp,
  output logic       enc_chg,
  output logic       enc_dir,
  output logic       enc_err,
  output logic       err_sticky,
  output logic       primed
);

  logic [1:0]       w_sync;
  logic [1:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_inp;
  logic             r_chg;
  logic             r_dir;
  logic             r_err;
  logic             r_sticky;
  logic             r_primed;
  logic             w_differs;
  logic             w_cnt_last;
  logic             w_commit;
  logic             w_step_fwd;
  logic             w_step_rev;
  logic             w_jump;

  sync_chain #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .Clkb (Clkb),
    .RSTb (RSTb),
    .d    ({enc_a, enc_b}),
    .q    (w_sync)
  );

  assign w_differs  = (w_sync != r_cand);
  assign w_cnt_last = (r_cnt == CNT_W'(DEB_CYCLES - 1));

  always_ff @(negedge Clkb or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= ST_STABLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A change back to the committed value is a returning glitch: drop straight to stable
  always_comb begin
    w_state_nxt = r_state;
    if (w_differs) begin
      w_state_nxt = (w_sync == r_inp) ? ST_STABLE : ST_QUAL;
    end else if (r_state == ST_QUAL && w_cnt_last) begin
      w_state_nxt = ST_STABLE;
    end
  end

  always_comb begin
    w_commit   = 1'b0;
    w_step_fwd = 1'b0;
    w_step_rev = 1'b0;
    w_jump     = 1'b0;
    if (!w_differs && r_state == ST_QUAL && w_cnt_last) begin
      w_commit = 1'b1;
    end
    if (w_commit && r_primed) begin
      w_step_fwd = (r_cand == gray_next(r_inp));
      w_step_rev = (gray_next(r_cand) == r_inp);
      w_jump     = ((r_cand ^ r_inp) == 2'b11);
    end
  end

  always_ff @(negedge Clkb or negedge RSTb) begin
    if (!RSTb) begin
      r_cand   <= 2'b00;
      r_cnt    <= '0;
      r_inp    <= 2'b00;
      r_chg    <= 1'b0;
      r_dir    <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_chg <= w_step_fwd | w_step_rev;
      r_err <= w_jump;
      if (w_differs) begin
        r_cand <= w_sync;
        r_cnt  <= '0;
      end else if (r_state == ST_QUAL) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_commit) begin
        r_inp    <= r_cand;
        r_primed <= 1'b1;
      end
      if (w_step_fwd) begin
        r_dir <= DIR_FWD;
      end else if (w_step_rev) begin
        r_dir <= DIR_REV;
      end
      // A coinciding error commit outranks the clear
      if (w_jump) begin
        r_sticky <= 1'b1;
      end else if (err_clr) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign enc_inp    = r_inp;
  assign enc_chg    = r_chg;
  assign enc_dir    = r_dir;
  assign enc_err    = r_err;
  assign err_sticky = r_sticky;
  assign primed     = r_primed;

endmodule
